// File: rtl/writeback_pkg.sv
// Shared widths and types for the add datapath's write-back stage and its neighbours.
package writeback_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_regfile_2r1w.sv
// Register file: NREGS x DATA_W, two combinational reads, one synchronous write, r0 reads 0.
module regfile_2r1w
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_1_i,
  input  logic [ADDR_W-1:0] raddr_2_i,
  output logic [DATA_W-1:0] rdata_1_o,
  output logic [DATA_W-1:0] rdata_2_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_1_o = (raddr_1_i == REG_ZERO) ? '0 : regs_q[raddr_1_i];
    rdata_2_o = (raddr_2_i == REG_ZERO) ? '0 : regs_q[raddr_2_i];
  end

endmodule

// File: rtl/writeback.sv
// Write-back stage: single pending slot between execute and the register file,
// with bypass from the slot onto both decode read ports.
module writeback
  import writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              commit_en,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic [31:0]       retire_count,
  output logic [ADDR_W-1:0] last_dest,
  output logic [DATA_W-1:0] last_data
);

  logic              p_valid_q;
  wb_entry_t         pend_q;
  logic [31:0]       retire_q;
  wb_entry_t         last_q;
  logic              commit;
  logic              xfer;
  logic [DATA_W-1:0] rf_rdata_1;
  logic [DATA_W-1:0] rf_rdata_2;

  assign wb_ready = !p_valid_q || commit_en;
  assign commit   = p_valid_q && commit_en;
  assign xfer     = wb_valid && wb_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      pend_q    <= '0;
      retire_q  <= '0;
      last_q    <= '0;
    end else begin
      if (commit) begin
        retire_q <= retire_q + 32'd1;
        last_q   <= pend_q;
      end
      // A same-cycle transfer refills the slot the committing entry just vacated.
      if (xfer) begin
        p_valid_q   <= 1'b1;
        pend_q.dest <= wb_dest;
        pend_q.data <= wb_data;
      end else if (commit) begin
        p_valid_q <= 1'b0;
      end
    end
  end

  regfile_2r1w u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (commit),
    .waddr_i   (pend_q.dest),
    .wdata_i   (pend_q.data),
    .raddr_1_i (rd_addr_1),
    .raddr_2_i (rd_addr_2),
    .rdata_1_o (rf_rdata_1),
    .rdata_2_o (rf_rdata_2)
  );

  always_comb begin
    rd_data_1 = rf_rdata_1;
    rd_data_2 = rf_rdata_2;
    if (rd_addr_1 == REG_ZERO) begin
      rd_data_1 = '0;
    end else if (p_valid_q && (pend_q.dest == rd_addr_1)) begin
      rd_data_1 = pend_q.data;
    end
    if (rd_addr_2 == REG_ZERO) begin
      rd_data_2 = '0;
    end else if (p_valid_q && (pend_q.dest == rd_addr_2)) begin
      rd_data_2 = pend_q.data;
    end
  end

  assign retire_count = retire_q;
  assign last_dest    = last_q.dest;
  assign last_data    = last_q.data;

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: reference model of slot/regfile, expected post-edge state queued per cycle.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        commit_en;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;
  logic [31:0] retire_count;
  logic [4:0]  last_dest;
  logic [31:0] last_data;

  writeback dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .commit_en    (commit_en),
    .rd_addr_1    (rd_addr_1),
    .rd_addr_2    (rd_addr_2),
    .rd_data_1    (rd_data_1),
    .rd_data_2    (rd_data_2),
    .retire_count (retire_count),
    .last_dest    (last_dest),
    .last_data    (last_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [4:0]  ld;
    logic [31:0] ldat;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_regs [32];
  logic        m_pv;
  logic [4:0]  m_pd;
  logic [31:0] m_pdat;
  logic [31:0] m_cnt;
  logic [4:0]  m_ld;
  logic [31:0] m_ldat;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_pv && (m_pd == a)) return m_pdat;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pv = 1'b0; m_pd = '0; m_pdat = '0;
    m_cnt = '0; m_ld = '0; m_ldat = '0;
  endtask

  // One clock: drive at negedge, check pre-edge ready/reads, predict, then compare after the edge.
  task automatic cycle(input logic v, input logic [4:0] d, input logic [31:0] dat,
                       input logic ce, input logic [4:0] a1, input logic [4:0] a2);
    logic m_ready, com, xf;
    exp_t e, got;
    @(negedge clk);
    wb_valid = v; wb_dest = d; wb_data = dat; commit_en = ce;
    rd_addr_1 = a1; rd_addr_2 = a2;
    #1;
    m_ready = !m_pv || ce;
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, m_ready});
    chk("rd1_pre", rd_data_1, mread(a1));
    chk("rd2_pre", rd_data_2, mread(a2));
    com = m_pv && ce;
    xf  = v && m_ready;
    if (com) begin
      if (m_pd != 5'd0) m_regs[m_pd] = m_pdat;
      m_cnt  = m_cnt + 32'd1;
      m_ld   = m_pd;
      m_ldat = m_pdat;
    end
    if (xf) begin
      m_pv = 1'b1; m_pd = d; m_pdat = dat;
    end else if (com) begin
      m_pv = 1'b0;
    end
    e.cnt = m_cnt; e.ld = m_ld; e.ldat = m_ldat; e.r1 = mread(a1); e.r2 = mread(a2);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("retire_count", retire_count, got.cnt);
    chk("last_dest", {27'd0, last_dest}, {27'd0, got.ld});
    chk("last_data", last_data, got.ldat);
    chk("rd1_post", rd_data_1, got.r1);
    chk("rd2_post", rd_data_2, got.r2);
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_dest = '0; wb_data = '0; commit_en = 1'b0;
    rd_addr_1 = '0; rd_addr_2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i += 2) begin
      rd_addr_1 = 5'(i); rd_addr_2 = 5'(i + 1);
      #1;
      chk("rst_rd1", rd_data_1, 32'd0);
      chk("rst_rd2", rd_data_2, 32'd0);
    end
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // single write: bypass after accept, regfile after commit
    cycle(1'b1, 5'd3, 32'h76E5A675, 1'b1, 5'd3, 5'd0);
    cycle(1'b0, 5'd0, 32'd0,        1'b1, 5'd3, 5'd3);

    // streaming at full rate
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 5'(i), 32'(i * 'h11), 1'b1, 5'(i), 5'(i - 1));
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd2);

    // stall with a second offer pending
    cycle(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 5'd6);
    repeat (3) cycle(1'b1, 5'd6, 32'hBB, 1'b0, 5'd5, 5'd6);
    cycle(1'b1, 5'd6, 32'hBB, 1'b1, 5'd5, 5'd6);
    cycle(1'b0, 5'd0, 32'd0,  1'b1, 5'd5, 5'd6);

    // r0 writes retire but never land
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 5'd0);

    // same destination back to back: later wins
    cycle(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 5'd9);
    cycle(1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 5'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);

    // random traffic
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2);

    // reset with an uncommitted entry
    cycle(1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 5'd3);
    @(negedge clk);
    wb_valid = 1'b0; commit_en = 1'b0; rd_addr_1 = 5'd7; rd_addr_2 = 5'd3;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_rd7", rd_data_1, 32'd0);
    chk("mid_rst_rd3", rd_data_2, 32'd0);
    chk("mid_rst_retire", retire_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd3);
    cycle(1'b1, 5'd8, 32'h1234, 1'b1, 5'd8, 5'd7);
    cycle(1'b0, 5'd0, 32'd0,    1'b1, 5'd8, 5'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
